// File: rtl/wb_slave_router_if.sv
// Wishbone bundle for wb_slave_router: upstream master port plus the shared
// and per-slave downstream signals.
interface wb_slave_router_if #(
  parameter int NUM_SLV = 4,
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32
);
  logic                     m_cyc_i;
  logic                     m_stb_i;
  logic                     m_we_i;
  logic [DAT_W/8-1:0]       m_sel_i;
  logic [ADR_W-1:0]         m_adr_i;
  logic [DAT_W-1:0]         m_dat_i;
  logic                     m_ack_o;
  logic [DAT_W-1:0]         m_dat_o;
  logic [NUM_SLV-1:0]       s_cyc_o;
  logic [NUM_SLV-1:0]       s_stb_o;
  logic                     s_we_o;
  logic [DAT_W/8-1:0]       s_sel_o;
  logic [ADR_W-1:0]         s_adr_o;
  logic [DAT_W-1:0]         s_dat_o;
  logic [NUM_SLV-1:0]       s_ack_i;
  logic [NUM_SLV*DAT_W-1:0] s_dat_i;

  // Router view: a Wishbone slave upstream that fans out to the downstream slaves.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_slave_router.sv
// Wishbone classic router: decodes the master address onto one of NUM_SLV slaves,
// registers the response, and answers unmapped, timed-out or aborted cycles itself.
module wb_slave_router #(
  parameter int                       NUM_SLV  = 4,
  parameter int                       ADR_W    = 32,
  parameter int                       DAT_W    = 32,
  parameter logic [NUM_SLV*ADR_W-1:0] SLV_BASE = {32'h3000_3000, 32'h3000_2000,
                                                  32'h3000_1000, 32'h3000_0000},
  parameter logic [NUM_SLV*ADR_W-1:0] SLV_MASK = {4{32'hFFFF_F000}},
  parameter int                       TIMEOUT  = 255,
  parameter logic [DAT_W-1:0]         ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  wb_slave_router_if.slave bus,
  output logic             err_o,
  output logic             timeout_o,
  output logic             busy_o
);

  localparam int               IDX_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam int               SEL_W    = DAT_W / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SLV-1:0] stb_q, stb_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   bsel_q, bsel_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   wdat_q, wdat_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               sel_ack;
  logic [DAT_W-1:0]   sel_dat;

  // Walk from the top index down so the lowest matching window is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((bus.m_adr_i & SLV_MASK[i*ADR_W +: ADR_W]) ==
          (SLV_BASE[i*ADR_W +: ADR_W] & SLV_MASK[i*ADR_W +: ADR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ack = bus.s_ack_i[idx_q];
  assign sel_dat = bus.s_dat_i[int'(idx_q)*DAT_W +: DAT_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    we_d    = we_q;
    bsel_d  = bsel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          adr_d  = bus.m_adr_i;
          wdat_d = bus.m_dat_i;
          bsel_d = bus.m_sel_i;
          we_d   = bus.m_we_i;
          idx_d  = hit_idx;
          cnt_d  = '0;
          stb_d  = '0;
          if (hit) begin
            stb_d[hit_idx] = 1'b1;
            state_d        = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      // A master abort beats a same-cycle ack; an ack beats watchdog expiry.
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.m_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          rdat_d  = sel_dat;
          stb_d   = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdat_d  = ERR_DATA;
          stb_d   = '0;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      ERR: begin
        rdat_d  = ERR_DATA;
        ack_d   = 1'b1;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        stb_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      bsel_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      bsel_q  <= bsel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.s_cyc_o = stb_q;
  assign bus.s_stb_o = stb_q;
  assign bus.s_we_o  = we_q;
  assign bus.s_sel_o = bsel_q;
  assign bus.s_adr_o = adr_q;
  assign bus.s_dat_o = wdat_q;
  assign bus.m_ack_o = ack_q;
  assign bus.m_dat_o = rdat_q;
  assign err_o       = err_q;
  assign timeout_o   = tmo_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/wb_slave_router.md
Name: wb_slave_router

Overview:
- Parametrised Wishbone classic slave-side router for the user area.
- Takes the single management-SoC Wishbone port and steers each transaction to one of NUM_SLV downstream slaves (UART, DMA, user project, …) by address-window decode.
- Registers the selected slave's response back to the master.
- Replaces hand-written ack/data muxing with a per-transaction FSM that adds bus-error responses for unmapped addresses, a timeout watchdog and master-abort handling.

Parameters:
- NUM_SLV, 4, number of downstream slaves (1..8)
- ADR_W, 32, address width
- DAT_W, 32, data width
- SLV_BASE, {32'h3000_3000,32'h3000_2000,32'h3000_1000,32'h3000_0000}, packed NUM_SLV*ADR_W base addresses; slave i in bits [i*ADR_W +: ADR_W]
- SLV_MASK, {4{32'hFFFF_F000}}, packed NUM_SLV*ADR_W compare masks
- TIMEOUT, 255, cycles to wait for a slave ack before aborting (>=2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error or timeout

Ports:
- wb_clk_i  in  1  clock
- wb_rstn_i  in  1  reset, asynchronous, active-low
- m_cyc_i  in  1  master cycle
- m_stb_i  in  1  master strobe
- m_we_i  in  1  master write enable
- m_sel_i  in  DAT_W/8  byte selects
- m_adr_i  in  ADR_W  address
- m_dat_i  in  DAT_W  write data
- m_ack_o  out  1  ack to master
- m_dat_o  out  DAT_W  read data to master
- s_cyc_o  out  NUM_SLV  per-slave cycle
- s_stb_o  out  NUM_SLV  per-slave strobe
- s_we_o  out  1  shared write enable
- s_sel_o  out  DAT_W/8  shared byte selects
- s_adr_o  out  ADR_W  shared address
- s_dat_o  out  DAT_W  shared write data
- s_ack_i  in  NUM_SLV  per-slave ack
- s_dat_i  in  NUM_SLV*DAT_W  packed per-slave read data
- err_o  out  1  one-cycle pulse on unmapped-address response
- timeout_o  out  1  one-cycle pulse on watchdog expiry
- busy_o  out  1  high while FSM is not IDLE

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; latched request, selected index and counter cleared.
  - Reset asserted mid-transaction drops every s_cyc_o/s_stb_o immediately (asynchronous); no ack is issued.
- Decode: slave i hits when (m_adr_i & MASK_i) == (BASE_i & MASK_i). On multiple hits the lowest index wins.
- FSM states:
  - IDLE:
    - Waits for m_cyc_i & m_stb_i.
    - On a request, latches adr/dat/sel/we into s_*_o and records the selected index.
    - On a hit, goes to BUSY; on no hit, goes to ERR.
  - BUSY:
    - s_cyc_o[sel] and s_stb_o[sel] are high; all other bits are 0.
    - Watchdog counter increments every cycle from 0.
    - On s_ack_i[sel]: captures that slave's s_dat_i slice into m_dat_o, drops cyc/stb the next cycle, goes to RESP.
    - Acks from non-selected slaves are ignored.
    - When the counter reaches TIMEOUT-1 without an ack: m_dat_o=ERR_DATA, drop cyc/stb, pulse timeout_o, go to RESP.
    - If m_cyc_i falls while in BUSY (master abort): drop cyc/stb next cycle, go to IDLE, no m_ack_o.
  - ERR: m_dat_o=ERR_DATA, pulse err_o, go to RESP. The slave strobe is never asserted.
  - RESP: m_ack_o=1 for exactly one cycle, then IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; slave strobe is high at cycle 1.
  - Slave ack at cycle k gives m_ack_o at cycle k+1. With a zero-wait slave (ack in cycle 1), m_ack_o is at cycle 2.
  - Unmapped address: m_ack_o at cycle 2.
- m_dat_o:
  - Holds its value after RESP until the next capture.
  - On writes it carries the captured slave data, which the master ignores.
- Back-to-back: the next request is accepted in the first IDLE cycle after RESP. Wishbone classic masters drop stb after ack, so no duplicate issue occurs.
- busy_o is high in BUSY, ERR and RESP.
- Slave ack arriving in the same cycle as watchdog expiry: the ack wins. Data is captured, no timeout_o.

Test Plan:
- Write 32'h1234_5678 sel=4'hF to 32'h3000_1004; slave1 acks 2 cycles after strobe -> only s_stb_o[1] high, s_dat_o=32'h1234_5678; m_ack_o exactly one cycle, 1 cycle after the slave ack.
- Read 32'h3000_2008; slave2 returns 32'hCAFE_0002 with zero-wait ack; slave0 drives 32'hFFFF_FFFF with a spurious ack -> m_dat_o=32'hCAFE_0002, m_ack_o at cycle 2, slave0 ack ignored.
- Read 32'h3100_0000 (unmapped) -> no s_stb_o bit set; m_dat_o=32'hDEAD_BEEF, err_o pulse, m_ack_o at cycle 2.
- TIMEOUT=8; read 32'h3000_3000 with slave3 never acking -> s_stb_o[3] high for 8 cycles, then timeout_o pulse, m_ack_o with 32'hDEAD_BEEF. Repeat with ack on the expiry cycle -> slave data returned, no timeout_o.
- Master drops m_cyc_i 1 cycle into BUSY -> s_cyc_o=0 next cycle, no m_ack_o, busy_o low; the following request to slave0 completes normally.
- wb_rstn_i low while s_stb_o[2] is high -> all outputs 0 immediately. After release, an overlapping-window config (SLV_MASK0=0, matches everything) routes 32'h3000_2000 to slave0 (lowest index wins).
